// File: rtl/ascii_scroll_buffer.sv
// rtl/ascii_scroll_buffer.sv - ASCII message store and five-character scroller (option: ASCII_SCROLL_FILTER_EN)
module ascii_scroll_buffer #(
    parameter int MSG_DEPTH = 32,
    parameter int TICK_DIV  = 25000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Clear,
    input  logic       Pause,
    input  logic [7:0] CharIn,
    input  logic       CharValid,
    input  logic       MsgEnd,
    output logic       CharReady,
    output logic [7:0] Message4,
    output logic [7:0] Message3,
    output logic [7:0] Message2,
    output logic [7:0] Message1,
    output logic [7:0] Message0,
    output logic       Scrolling
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] LAST_SLOT = PW'(MSG_DEPTH - 1);
    localparam logic [PW-1:0] SHORT_LEN = PW'(5);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]    SPACE     = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCROLL
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [MSG_DEPTH];
    logic [PW-1:0] wr_ptr, len, offset;
    logic [TW-1:0] tick;
    logic          accept, keep, msg_done, long_msg, advance;
    logic [PW-1:0] end_len;
    logic [PW-1:0] idx;
    logic [7:0]    win [5];

`ifdef ASCII_SCROLL_FILTER_EN
    function automatic logic is_kept(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h5A) ||
               (c >= 8'h61 && c <= 8'h7A) || (c == SPACE);
    endfunction
    assign keep = is_kept(CharIn);
`else
    assign keep = 1'b1;
`endif

    assign CharReady = (state == IDLE || state == LOAD) && !Clear && !Rst;
    assign accept    = CharValid && CharReady;
    // The last slot ends the message even without MsgEnd.
    assign msg_done  = accept && (MsgEnd || wr_ptr == LAST_SLOT);
    assign end_len   = wr_ptr + {{AW{1'b0}}, keep};
    assign long_msg  = len > SHORT_LEN;
    assign advance   = (state == SCROLL) && long_msg && !Pause;
    assign Scrolling = (state == SCROLL) && long_msg;

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (Clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (msg_done)
                        state_nxt = (end_len == '0) ? IDLE : SCROLL;
                    else if (accept)
                        state_nxt = LOAD;
                end
                SCROLL:  state_nxt = SCROLL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (accept && keep)
            mem[wr_ptr[AW-1:0]] <= CharIn;
    end

    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            wr_ptr <= '0;
            len    <= '0;
            offset <= '0;
            tick   <= '0;
        end else begin
            if (accept && keep)
                wr_ptr <= wr_ptr + PW'(1);
            if (msg_done) begin
                len    <= end_len;
                offset <= '0;
                tick   <= '0;
            end else if (advance) begin
                if (tick == TICK_LAST) begin
                    tick   <= '0;
                    offset <= (offset == len) ? '0 : offset + PW'(1);
                end else begin
                    tick <= tick + TW'(1);
                end
            end
        end
    end

    // Virtual string is the message followed by one space at position len.
    always_comb begin
        idx = '0;
        for (int i = 0; i < 5; i++) begin
            win[i] = SPACE;
            if (state == SCROLL) begin
                if (long_msg) begin
                    idx = offset + PW'(i);
                    if (idx > len)
                        idx = idx - (len + PW'(1));
                    if (idx != len)
                        win[i] = mem[idx[AW-1:0]];
                end else if (PW'(i) < len) begin
                    win[i] = mem[AW'(i)];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            Message4 <= SPACE;
            Message3 <= SPACE;
            Message2 <= SPACE;
            Message1 <= SPACE;
            Message0 <= SPACE;
        end else begin
            Message4 <= win[0];
            Message3 <= win[1];
            Message2 <= win[2];
            Message1 <= win[3];
            Message0 <= win[4];
        end
    end

endmodule

// File: tb/tb_ascii_scroll_buffer.sv
// tb/tb_ascii_scroll_buffer.sv - scoreboard bench for ascii_scroll_buffer with a queue-based reference model
module tb_ascii_scroll_buffer;

    localparam int DEPTH = 8;
    localparam int TDIV  = 4;
    localparam logic [39:0] BLANK = {5{8'h20}};

    logic       Clk = 1'b0;
    logic       Rst, Clear, Pause, CharValid, MsgEnd;
    logic [7:0] CharIn;
    logic       CharReady, Scrolling;
    logic [7:0] Message4, Message3, Message2, Message1, Message0;
    logic [39:0] win_act;

    always #5 Clk = ~Clk;
    assign win_act = {Message4, Message3, Message2, Message1, Message0};

    ascii_scroll_buffer #(.MSG_DEPTH(DEPTH), .TICK_DIV(TDIV)) dut (
        .Clk(Clk), .Rst(Rst), .Clear(Clear), .Pause(Pause),
        .CharIn(CharIn), .CharValid(CharValid), .MsgEnd(MsgEnd),
        .CharReady(CharReady),
        .Message4(Message4), .Message3(Message3), .Message2(Message2),
        .Message1(Message1), .Message0(Message0),
        .Scrolling(Scrolling)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: message kept as a byte queue, window by modular indexing.
    typedef struct {
        logic [39:0] win;
        bit          scr;
        bit          rdy;
    } exp_t;

    exp_t         sb[$];
    int           m_state = 0;
    byte unsigned m_buf[$];
    int           m_off = 0;
    int           m_tick = 0;
    logic [39:0]  m_win = BLANK;

`ifdef ASCII_SCROLL_FILTER_EN
    function automatic bit kept(input byte unsigned c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") ||
               (c >= "a" && c <= "z") || (c == " ");
    endfunction
`endif

    function automatic logic [39:0] model_window();
        logic [39:0]  w;
        int           n;
        int           k;
        byte unsigned c;
        w = BLANK;
        n = m_buf.size();
        if (m_state == 2) begin
            for (int i = 0; i < 5; i++) begin
                c = 8'h20;
                if (n > 5) begin
                    k = (m_off + i) % (n + 1);
                    if (k < n) c = m_buf[k];
                end else if (i < n) begin
                    c = m_buf[i];
                end
                w[8*(4-i) +: 8] = c;
            end
        end
        return w;
    endfunction

    function void model_step();
        logic [39:0] nxt;
        int          n;
        bit          keep;
        bit          full;
        exp_t        e;
        nxt = model_window();
        if (Rst || Clear) begin
            m_state = 0;
            m_buf.delete();
            m_off   = 0;
            m_tick  = 0;
            m_win   = BLANK;
        end else begin
            m_win = nxt;
            n = m_buf.size();
            if (m_state != 2) begin
                if (CharValid) begin
                    keep = 1'b1;
`ifdef ASCII_SCROLL_FILTER_EN
                    keep = kept(CharIn);
`endif
                    full = (n == DEPTH - 1);
                    if (keep) m_buf.push_back(CharIn);
                    if (MsgEnd || full) begin
                        m_state = (m_buf.size() == 0) ? 0 : 2;
                        m_off   = 0;
                        m_tick  = 0;
                    end else begin
                        m_state = 1;
                    end
                end
            end else if (n > 5 && !Pause) begin
                m_tick++;
                if (m_tick == TDIV) begin
                    m_tick = 0;
                    m_off  = (m_off + 1) % (n + 1);
                end
            end
        end
        e.win = m_win;
        e.scr = (m_state == 2) && (m_buf.size() > 5);
        e.rdy = (m_state != 2);
        sb.push_back(e);
    endfunction

    // Monitor: the DUT presents a window every cycle; compare it away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_window", win_act, e.win);
                check("sb_scrolling", Scrolling, e.scr);
                check("sb_charready", CharReady, e.rdy && !Clear && !Rst);
            end
        end
    end

    task automatic cyc(input bit rst, input bit clr, input bit pse, input bit vld,
                       input byte unsigned ch, input bit eom);
        Rst = rst; Clear = clr; Pause = pse; CharValid = vld; CharIn = ch; MsgEnd = eom;
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n, input bit pse);
        for (int i = 0; i < n; i++) cyc(0, 0, pse, 0, 8'h00, 0);
    endtask

    task automatic send_str(input string s, input bit end_last);
        for (int k = 0; k < s.len(); k++)
            cyc(0, 0, 0, 1, s[k], end_last && (k == s.len() - 1));
    endtask

    function automatic byte unsigned rand_char();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return byte'($urandom_range(65, 90));
        if (r < 7) return byte'($urandom_range(97, 122));
        return byte'($urandom_range(32, 126));
    endfunction

    initial begin
        int mlen;
        bit pse;
        Rst = 1; Clear = 0; Pause = 0; CharValid = 0; CharIn = 0; MsgEnd = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("reset_window", win_act, BLANK);
        check("reset_charready", CharReady, 1'b0);
        check("reset_scrolling", Scrolling, 1'b0);

        send_str("Hello", 1);
        idle(1, 0);
        check("hello_window", win_act, "Hello");
        check("hello_scrolling", Scrolling, 1'b0);
        check("hello_charready", CharReady, 1'b0);

        cyc(0, 1, 0, 0, 0, 0);
        send_str("World!", 1);
        idle(1, 0);
        check("world_step0", win_act, "World");
        idle(4, 0);
        check("world_step1", win_act, "orld!");
        idle(4, 0);
        check("world_step2", win_act, "rld! ");
        idle(20, 1);
        check("pause_hold", win_act, "rld! ");
        idle(4, 0);
        check("pause_resume", win_act, "ld! W");
        idle(4 * 4, 0);
        check("world_wrap", win_act, "World");

        cyc(0, 1, 0, 0, 0, 0);
        send_str("ABCDEFGH", 0);
        idle(1, 0);
        check("full_scrolling", Scrolling, 1'b1);
        check("full_charready", CharReady, 1'b0);
        check("full_window", win_act, "ABCDE");

        cyc(0, 1, 0, 0, 0, 0);
        send_str("XY", 0);
        Rst = 0; Clear = 1; Pause = 0; CharValid = 1; CharIn = "Z"; MsgEnd = 1;
        model_step();
        #1;
        check("collide_charready", CharReady, 1'b0);
        @(posedge Clk);
        #1;
        idle(1, 0);
        check("collide_window", win_act, BLANK);
        check("collide_idle_ready", CharReady, 1'b1);
        send_str("AB", 1);
        idle(1, 0);
        check("ab_window", win_act, "AB   ");

`ifdef ASCII_SCROLL_FILTER_EN
        cyc(0, 1, 0, 0, 0, 0);
        send_str("a#b", 0);
        cyc(0, 0, 0, 1, "%", 1);
        idle(1, 0);
        check("filter_window", win_act, "ab   ");
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, "#", 1);
        idle(1, 0);
        check("filter_empty_window", win_act, BLANK);
        check("filter_empty_ready", CharReady, 1'b1);
`endif

        for (int m = 0; m < 40; m++) begin
            cyc(0, 1, 0, 0, 0, 0);
            mlen = $urandom_range(1, 10);
            for (int k = 0; k < mlen; k++) begin
                idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 39) == 0)
                    cyc(0, 1, 0, 1, rand_char(), 0);
                else if ($urandom_range(0, 59) == 0)
                    cyc(1, 0, 0, 1, rand_char(), 0);
                else
                    cyc(0, 0, 0, 1, rand_char(), (k == mlen - 1) && ($urandom_range(0, 3) != 0));
            end
            for (int c = 0; c < $urandom_range(10, 80); c++) begin
                pse = ($urandom_range(0, 4) == 0);
                cyc(0, 0, pse, ($urandom_range(0, 7) == 0), rand_char(), 1'($urandom_range(0, 1)));
            end
        end

        idle(2, 0);
        @(negedge Clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ascii_scroll_buffer.md
# ascii_scroll_buffer

Message store and scroller that sits directly upstream of the five ASCII-to-seven-segment decoders. It accepts a byte stream of ASCII characters over a valid/ready handshake and stores up to MSG_DEPTH of them. It then presents a registered five-character window on Message4..Message0, one byte per decoder. Messages longer than five characters scroll left by one position per tick, with a single space separating the end of the message from its restart.

## Interface
Parameters:
- MSG_DEPTH, 32: maximum stored characters; power of two, at least 8.
- TICK_DIV, 25000000: Clk cycles per scroll step; at least 2.

Ports:
- Clk  input  1  single clock; all state is updated on its rising edge.
- Rst  input  1  reset, synchronous and active-high.
- Clear  input  1  discards the stored message and returns to IDLE.
- Pause  input  1  while high, freezes the tick counter and scroll offset.
- CharIn  input  8  ASCII character.
- CharValid  input  1  CharIn/MsgEnd are valid.
- MsgEnd  input  1  the current character is the last of the message.
- CharReady  output  1  block can accept a character this cycle.
- Message4..Message0  output  8 each  window characters; Message4 is the leftmost.
- Scrolling  output  1  high in SCROLL state with Len > 5.

## Operation
- State machine: IDLE, LOAD, SCROLL.
  - Internal registers: wr_ptr, Len, offset (each clog2(MSG_DEPTH)+1 bits) and tick counter.
- Rst: state IDLE, wr_ptr=0, Len=0, offset=0, tick=0. Outputs: CharReady=0 during Rst, Message4..0=8'h20, Scrolling=0.
- CharReady = (state is IDLE or LOAD) and not Clear and not Rst. This is combinational.
- Accept means CharValid and CharReady in the same cycle. Each accept does the following:
  - stores CharIn at buf[wr_ptr] and increments wr_ptr;
  - moves IDLE to LOAD;
  - ends the message if MsgEnd=1 or wr_ptr==MSG_DEPTH-1. Ending sets Len=wr_ptr+1, offset=0, tick=0 and moves to SCROLL.
- Window: index i=0..4 drives Message(4-i).
  - Virtual string length V=Len+1. Position Len is a space (8'h20).
  - If Len>5: Message(4-i)=vchar[(offset+i) mod V].
  - If Len<=5: offset stays 0; Message(4-i)=buf[i] for i<Len, otherwise 8'h20.
- IDLE and LOAD: Message4..0=8'h20. A partial message is never displayed.
- SCROLL with Len>5 and Pause=0:
  - tick counts 0..TICK_DIV-1;
  - on tick==TICK_DIV-1, tick returns to 0 and offset=(offset+1) mod V.
- Pause=1: tick and offset hold. Pause has no effect in IDLE or LOAD.
- Clear (any state): next cycle state=IDLE, wr_ptr=0, Len=0, offset=0, tick=0, Message4..0=8'h20. Clear takes priority over a simultaneous CharValid; that character is not accepted.
- Rst takes priority over Clear. Rst mid-LOAD discards the partial message.

## Timing
- CharReady is combinational; the handshake completes in the same cycle.
- Accept with MsgEnd at cycle N: state=SCROLL at N+1; Message4..0 show the first window at N+2.
- Window outputs are registered and lag the offset by one cycle. With Pause=0, an offset step occurs every TICK_DIV cycles after entering SCROLL.
- Wrap-around: after offset V-1, the next step gives offset 0. Period = V*TICK_DIV cycles.
- A new message requires Clear; characters presented in SCROLL are held off (CharReady=0).

## Configuration
- ASCII_SCROLL_FILTER_EN defined:
  - Accepted characters outside 0-9, A-Z, a-z and 8'h20 are consumed but not stored; wr_ptr does not increment.
  - MsgEnd on a dropped character still ends the message.
  - If the resulting Len=0, the block returns to IDLE instead of SCROLL.
- ASCII_SCROLL_FILTER_EN undefined: every accepted byte is stored unchanged.

## Test plan
- Reset and short message: Rst, then load "Hello" with MsgEnd on 'o' -> two cycles later Message4..0 = 8'h48,65,6C,6C,6F; Scrolling=0; CharReady=0.
- Scrolling (TICK_DIV=4): load "World!" -> window "World", then every 4 cycles "orld!", "rld! ", "ld! W", …, returning to "World" after 7 steps.
- Pause mid-scroll: Pause=1 for 20 cycles -> window and offset constant; scrolling resumes with the remaining tick count.
- Full buffer (MSG_DEPTH=8): 8 characters with no MsgEnd -> implicit end after the 8th; Len=8; CharReady=0.
- Clear colliding with a character: Clear and CharValid in the same cycle during LOAD -> CharReady=0, nothing stored, next cycle IDLE with all outputs 8'h20; then "AB" loads normally -> "AB   ".
- With FILTER_EN: send "a#b" then '%' with MsgEnd -> "ab   ". Send a single '#' with MsgEnd -> IDLE, outputs 8'h20.
